nested_op_arbiter: RTL and testbench

NESTED_OP_ARBITER -- requirements
Module: nested_op_arbiter

---
 rtl/nested_op_pkg.sv | 49 ++++
 rtl/nested_op_picker.sv | 31 +++
 rtl/nested_op_arbiter.sv | 137 +++++++++++++
 tb/tb_nested_op_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nested_op_pkg.sv
// ============================================================================
// Module  : nested_op_pkg
// Brief   : Shared FSM states, datapath constants and grant selection helper
//           for nested_op_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package nested_op_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DIV  = 3'd1,
        MUL  = 3'd2,
        ADD  = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam int OP_DIV = 3;
    localparam int OP_MUL = 2;
    localparam int OP_ADD = 1;

    localparam int c_MAX_REQ = 8;

    // Scan num_req slots starting at ptr (wrapping); first set request wins.
    // Fixed priority is the same scan with ptr tied to zero.
    function automatic logic [c_MAX_REQ-1:0] pick_grant(
        input logic [c_MAX_REQ-1:0] req,
        input logic [2:0]           ptr,
        input int                   num_req
    );
        logic [c_MAX_REQ-1:0] gnt;
        logic                 found;
        logic [2:0]           idx;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < c_MAX_REQ; k++) begin
            idx = 3'((int'(ptr) + k) % num_req);
            if (k < num_req && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nested_op_picker.sv
// ============================================================================
// Module  : nested_op_picker
// Brief   : Combinational requester selection; round-robin from a pointer when
//           NESTED_OP_ROUND_ROBIN_EN is defined, fixed lowest-index otherwise.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nested_op_picker
    import nested_op_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
`ifdef NESTED_OP_ROUND_ROBIN_EN
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
`endif
    output logic [NUM_REQ-1:0]         gnt
);

    always_comb begin
`ifdef NESTED_OP_ROUND_ROBIN_EN
        gnt = NUM_REQ'(pick_grant(8'(req), 3'(ptr), NUM_REQ));
`else
        gnt = NUM_REQ'(pick_grant(8'(req), 3'd0, NUM_REQ));
`endif
    end

endmodule

`default_nettype wire

// File: rtl/nested_op_arbiter.sv
// ============================================================================
// Module  : nested_op_arbiter
// Brief   : Shares one sequenced ((x / 3) * 2) + 1 datapath among NUM_REQ
//           requesters. Define NESTED_OP_ROUND_ROBIN_EN for round-robin.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nested_op_arbiter
    import nested_op_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         busy,
    output logic                         rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [DATA_W-1:0]            rsp_data
);

    localparam int c_ID_W = $clog2(NUM_REQ);

    state_t              r_state;
    logic [DATA_W-1:0]   r_acc;
    logic [c_ID_W-1:0]   r_owner;
    logic                r_busy;
    logic                r_rsp_valid;
    logic [c_ID_W-1:0]   r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_data;

    logic [NUM_REQ-1:0]  w_pick;
    logic [c_ID_W-1:0]   w_gnt_idx;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_grant_ok;

`ifdef NESTED_OP_ROUND_ROBIN_EN
    logic [c_ID_W-1:0]   r_ptr;

    nested_op_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req (req),
        .ptr (r_ptr),
        .gnt (w_pick)
    );
`else
    nested_op_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req (req),
        .gnt (w_pick)
    );
`endif

    always_comb begin
        w_gnt_idx  = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) begin
                w_gnt_idx  = c_ID_W'(i);
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Grant is only offered in IDLE and never while reset is asserted.
    assign w_grant_ok = rst_n && (r_state == IDLE);
    assign gnt        = w_grant_ok ? w_pick : '0;

    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_owner     <= '0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
`ifdef NESTED_OP_ROUND_ROBIN_EN
            r_ptr       <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_rsp_valid <= 1'b0;
                    if (|w_pick) begin
                        r_acc   <= w_sel_data;
                        r_owner <= w_gnt_idx;
                        r_busy  <= 1'b1;
                        r_state <= DIV;
`ifdef NESTED_OP_ROUND_ROBIN_EN
                        r_ptr   <= (w_gnt_idx == c_ID_W'(NUM_REQ - 1)) ? '0
                                                                       : w_gnt_idx + 1'b1;
`endif
                    end
                end
                DIV: begin
                    r_acc   <= r_acc / DATA_W'(OP_DIV);
                    r_state <= MUL;
                end
                MUL: begin
                    r_acc   <= r_acc * DATA_W'(OP_MUL);
                    r_state <= ADD;
                end
                ADD: begin
                    r_rsp_data  <= r_acc + DATA_W'(OP_ADD);
                    r_rsp_id    <= r_owner;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nested_op_arbiter.sv
// ============================================================================
// Module  : tb_nested_op_arbiter
// Brief   : Self-checking bench for nested_op_arbiter; follows
//           NESTED_OP_ROUND_ROBIN_EN to pick the arbitration model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nested_op_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         gnt;
    logic                       busy;
    logic                       rsp_valid;
    logic [1:0]                 rsp_id;
    logic [DATA_W-1:0]          rsp_data;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase counts cycles since the grant (0 = idle).
    int          m_phase;
    int          m_ptr;
    int          m_id;
    logic [31:0] m_res;
    int          m_last_id;
    logic [31:0] m_last_data;

    int          cyc;
    int          n_valid;
    logic [3:0]  obs_gnt;
    logic        obs_valid;
    int          g_log[$];
    int          g_cyc[$];

    always #5 clk = ~clk;

    nested_op_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    function automatic logic [31:0] ref_result(input logic [31:0] x);
        longint unsigned v;
        v = longint'(x);
        v = ((v / 3) * 2 + 1) % 64'h1_0000_0000;
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_pick(input logic [3:0] r, input int ptr);
        int idx;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (ptr + k) % NUM_REQ;
            if (r[idx]) return 4'(1 << idx);
        end
        return 4'b0;
    endfunction

    function automatic int onehot_idx(input logic [3:0] g);
        for (int i = 0; i < NUM_REQ; i++) if (g[i]) return i;
        return -1;
    endfunction

    function automatic int exp_order(input int k);
`ifdef NESTED_OP_ROUND_ROBIN_EN
        return k % NUM_REQ;
`else
        return 0 * k;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs are already driven for this cycle; check outputs, advance model.
    task automatic cycle();
        logic [3:0] eg;
        #2;
        eg = (rst_n && m_phase == 0) ? ref_pick(req, m_ptr) : 4'b0;
        obs_gnt   = gnt;
        obs_valid = rsp_valid;
        check("gnt",       32'(gnt),       32'(eg));
        check("busy",      32'(busy),      32'(m_phase != 0));
        check("rsp_valid", 32'(rsp_valid), 32'(m_phase == 4));
        check("rsp_id",    32'(rsp_id),    32'(m_last_id));
        check("rsp_data",  rsp_data,       m_last_data);
        if (gnt != 4'b0) begin
            g_log.push_back(onehot_idx(gnt));
            g_cyc.push_back(cyc);
        end
        if (rsp_valid === 1'b1) n_valid++;
        if (!rst_n) begin
            m_phase     = 0;
            m_ptr       = 0;
            m_last_id   = 0;
            m_last_data = 32'd0;
        end else if (m_phase == 0) begin
            if (eg != 4'b0) begin
                m_id    = onehot_idx(eg);
                m_res   = ref_result(req_data[m_id*DATA_W +: DATA_W]);
                m_phase = 1;
`ifdef NESTED_OP_ROUND_ROBIN_EN
                m_ptr   = (m_id + 1) % NUM_REQ;
`endif
            end
        end else if (m_phase == 4) begin
            m_phase = 0;
        end else begin
            m_phase++;
            if (m_phase == 4) begin
                m_last_id   = m_id;
                m_last_data = m_res;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            lat++;
            if (obs_valid === 1'b1) break;
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 10 && m_phase != 0; c++) cycle();
    endtask

    task automatic set_lane(input int i, input logic [31:0] v);
        req_data[i*DATA_W +: DATA_W] = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int t0;
        int v0;

        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;
        m_phase = 0; m_ptr = 0; m_id = 0; m_res = '0;
        m_last_id = 0; m_last_data = '0;
        cyc = 0; n_valid = 0;
        @(posedge clk);
        #1;

        // Reset state
        cycle();
        cycle();
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_rsp_id",   32'(rsp_id),    32'd0);
        check("rst_rsp_data", rsp_data,       32'd0);
        rst_n = 1'b1;
        cycle();

        // Single request, data 30 -> 21
        req = 4'b0001; set_lane(0, 32'd30);
        cycle();
        check("s1_gnt", 32'(obs_gnt), 32'h1);
        req = 4'b0000;
        wait_rsp(lat);
        check("s1_lat",  32'(lat),      32'd4);
        check("s1_id",   32'(rsp_id),   32'd0);
        check("s1_data", rsp_data,      32'd21);

        // Requester 1 boundary operands
        req = 4'b0010; set_lane(1, 32'd0);
        cycle();
        check("s2_gnt", 32'(obs_gnt), 32'h2);
        req = 4'b0000;
        wait_rsp(lat);
        check("s2_id",   32'(rsp_id), 32'd1);
        check("s2_data", rsp_data,    32'd1);
        req = 4'b0010; set_lane(1, 32'hFFFF_FFFF);
        cycle();
        req = 4'b0000;
        wait_rsp(lat);
        check("s2_max_data", rsp_data, 32'hAAAA_AAAB);

        // All requesting, from a fresh pointer
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_lane(i, 32'(100 * i + 7));
        g_log.delete(); g_cyc.delete();
        for (int c = 0; c < 40 && g_log.size() < 5; c++) cycle();
        check("s4_count", 32'(g_log.size()), 32'd5);
        if (g_log.size() == 5) begin
            for (int k = 0; k < 5; k++) check("s4_order", 32'(g_log[k]), 32'(exp_order(k)));
            for (int k = 1; k < 5; k++) check("s4_gap", 32'(g_cyc[k] - g_cyc[k-1]), 32'd5);
        end
        req = 4'b0000;
        drain();

        // Request arriving while busy waits for IDLE
        req = 4'b0100; set_lane(2, 32'd600); set_lane(3, 32'd9);
        t0 = cyc;
        cycle();
        check("s5_gnt", 32'(obs_gnt), 32'h4);
        req = 4'b1000;
        g_log.delete(); g_cyc.delete();
        for (int c = 0; c < 10 && g_log.size() < 1; c++) cycle();
        check("s5_count", 32'(g_log.size()), 32'd1);
        if (g_log.size() == 1) begin
            check("s5_idx",   32'(g_log[0]),      32'd3);
            check("s5_delay", 32'(g_cyc[0] - t0), 32'd5);
        end
        req = 4'b0000;
        wait_rsp(lat);
        check("s5_data", rsp_data, 32'd7);

        // Reset during MUL aborts; held request granted after release
        req = 4'b0001; set_lane(0, 32'd1000);
        v0 = n_valid;
        cycle();
        check("s6_gnt", 32'(obs_gnt), 32'h1);
        cycle();
        rst_n = 1'b0;
        cycle();
        check("s6_busy_after_rst", 32'(busy), 32'd0);
        cycle();
        check("s6_no_gnt_in_rst", 32'(obs_gnt), 32'h0);
        check("s6_no_valid",      32'(n_valid - v0), 32'd0);
        rst_n = 1'b1;
        cycle();
        check("s6_regnt", 32'(obs_gnt), 32'h1);
        req = 4'b0000;
        wait_rsp(lat);
        check("s6_lat",  32'(lat), 32'd4);
        check("s6_data", rsp_data, 32'd667);

        // Short pulse while busy is forgotten
        req = 4'b0001; set_lane(0, 32'd5); set_lane(2, 32'd77);
        v0 = n_valid;
        cycle();
        req = 4'b0000;
        g_log.delete(); g_cyc.delete();
        cycle();
        req = 4'b0100;
        cycle();
        req = 4'b0000;
        for (int c = 0; c < 10; c++) cycle();
        check("s7_grants",  32'(g_log.size()),    32'd0);
        check("s7_valids",  32'(n_valid - v0),    32'd1);
        check("s7_data",    rsp_data,             32'd3);

        // Random traffic against the model
        for (int c = 0; c < 300; c++) begin
            req = 4'($urandom_range(0, 15));
            for (int i = 0; i < NUM_REQ; i++) set_lane(i, 32'($urandom));
            rst_n = ($urandom_range(0, 39) != 0);
            cycle();
        end
        rst_n = 1'b1;
        req   = 4'b0000;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
